cpu16_mem_arb: RTL

- Arbitrates the cpu16 instruction-fetch port and data port onto one shared single-ported 16-bit memory bus.
- Lets a cpu16 core run from a unified RAM instead of split instruction/data memories.
- Data accesses normally take priority; a burst limit prevents instruction-fetch starvation; a timeout prevents a dead slave from hanging the core.

---
 rtl/cpu16_mem_arb.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/cpu16_mem_arb.sv
// Shares one single-ported 16-bit memory bus between the cpu16 fetch and data ports.
// Data wins by default; a grant streak limit protects fetch, and a timeout aborts dead accesses.
module cpu16_mem_arb #(
    parameter int DAT_BURST_MAX  = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] ins_rd_addr,
    input  logic        ins_rd_req,
    output logic [15:0] ins_rd_data,
    output logic        ins_rd_rdy,
    input  logic [15:0] dat_rw_addr,
    input  logic [15:0] dat_wr_data,
    input  logic        dat_rd_req,
    input  logic        dat_wr_req,
    output logic [15:0] dat_rd_data,
    output logic        dat_rd_rdy,
    output logic        dat_wr_rdy,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_req,
    input  logic [15:0] mem_rdata,
    input  logic        mem_rdy,
    output logic        bus_err
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY_I = 2'd1;
    localparam logic [1:0] ST_BUSY_D = 2'd2;

    localparam logic [3:0] BURST_MAX = 4'(DAT_BURST_MAX);
    localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  streak_q, streak_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        mem_we_q, mem_we_d;
    logic        mem_req_q, mem_req_d;
    logic [15:0] ins_rd_data_q, ins_rd_data_d;
    logic [15:0] dat_rd_data_q, dat_rd_data_d;
    logic        ins_rd_rdy_q, ins_rd_rdy_d;
    logic        dat_rd_rdy_q, dat_rd_rdy_d;
    logic        dat_wr_rdy_q, dat_wr_rdy_d;
    logic        bus_err_q, bus_err_d;

    logic busy, done, abort, can_arb;
    logic ins_cand, dat_cand, grant_i, grant_d;

    assign busy    = (state_q != ST_IDLE);
    assign done    = busy && mem_rdy;
    // mem_rdy in the final allowed cycle still completes normally
    assign abort   = busy && !mem_rdy && (tmo_q == TMO_LAST);
    assign can_arb = !busy || done;

    // The port finishing this cycle still shows its old request level, so it sits out
    assign ins_cand = ins_rd_req && !(done && state_q == ST_BUSY_I);
    assign dat_cand = (dat_rd_req || dat_wr_req) && !(done && state_q == ST_BUSY_D);
    assign grant_i  = can_arb && ins_cand && (!dat_cand || streak_q == BURST_MAX);
    assign grant_d  = can_arb && dat_cand && !grant_i;

    always_comb begin
        state_d       = state_q;
        streak_d      = streak_q;
        tmo_d         = tmo_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_we_d      = mem_we_q;
        mem_req_d     = mem_req_q;
        ins_rd_data_d = ins_rd_data_q;
        dat_rd_data_d = dat_rd_data_q;
        ins_rd_rdy_d  = 1'b0;
        dat_rd_rdy_d  = 1'b0;
        dat_wr_rdy_d  = 1'b0;
        bus_err_d     = 1'b0;

        if (done || abort) begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
            bus_err_d = abort;
            if (state_q == ST_BUSY_I) begin
                ins_rd_rdy_d  = 1'b1;
                ins_rd_data_d = done ? mem_rdata : 16'hFFFF;
            end else if (mem_we_q) begin
                dat_wr_rdy_d = 1'b1;
            end else begin
                dat_rd_rdy_d  = 1'b1;
                dat_rd_data_d = done ? mem_rdata : 16'hFFFF;
            end
        end else if (busy) begin
            tmo_d = tmo_q + 8'd1;
        end

        if (grant_i) begin
            state_d    = ST_BUSY_I;
            mem_req_d  = 1'b1;
            mem_addr_d = ins_rd_addr;
            mem_we_d   = 1'b0;
            tmo_d      = 8'd0;
            streak_d   = 4'd0;
        end else if (grant_d) begin
            // A store beats a simultaneous load; the load waits for a later grant
            state_d     = ST_BUSY_D;
            mem_req_d   = 1'b1;
            mem_addr_d  = dat_rw_addr;
            mem_we_d    = dat_wr_req;
            mem_wdata_d = dat_wr_data;
            tmo_d       = 8'd0;
            if (!ins_rd_req) begin
                streak_d = 4'd0;
            end else if (streak_q != BURST_MAX) begin
                streak_d = streak_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            streak_q      <= 4'd0;
            tmo_q         <= 8'd0;
            mem_addr_q    <= 16'd0;
            mem_wdata_q   <= 16'd0;
            mem_we_q      <= 1'b0;
            mem_req_q     <= 1'b0;
            ins_rd_data_q <= 16'd0;
            dat_rd_data_q <= 16'd0;
            ins_rd_rdy_q  <= 1'b0;
            dat_rd_rdy_q  <= 1'b0;
            dat_wr_rdy_q  <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            streak_q      <= streak_d;
            tmo_q         <= tmo_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_we_q      <= mem_we_d;
            mem_req_q     <= mem_req_d;
            ins_rd_data_q <= ins_rd_data_d;
            dat_rd_data_q <= dat_rd_data_d;
            ins_rd_rdy_q  <= ins_rd_rdy_d;
            dat_rd_rdy_q  <= dat_rd_rdy_d;
            dat_wr_rdy_q  <= dat_wr_rdy_d;
            bus_err_q     <= bus_err_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_we      = mem_we_q;
    assign mem_req     = mem_req_q;
    assign ins_rd_data = ins_rd_data_q;
    assign dat_rd_data = dat_rd_data_q;
    assign ins_rd_rdy  = ins_rd_rdy_q;
    assign dat_rd_rdy  = dat_rd_rdy_q;
    assign dat_wr_rdy  = dat_wr_rdy_q;
    assign bus_err     = bus_err_q;

endmodule
